fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each requester data word.
REQ-002 Parameter NUM_REQ, default 4: number of write requesters, range 2..16.
REQ-003 Parameter FIFO_DEPTH, default 8: depth of the downstream synchronous FIFO, used as the credit count.
REQ-004 Parameter MAX_BURST, default 4: maximum consecutive accepts per grant when burst is compiled in.
REQ-005 clkIn  in  1: single clock; all logic is posedge clkIn.
REQ-006 rstNIn  in  1: reset, synchronous, active-low.
REQ-007 reqIn  in  NUM_REQ: per-requester write request.
REQ-008 reqDataIn  in  NUM_REQ*DATA_WIDTH: flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 ackOut  out  NUM_REQ: one-hot combinational accept; word i is consumed in the cycle ackOut[i]=1.
REQ-010 wrEnOut  out  1: registered FIFO write enable.
REQ-011 wrDataOut  out  DATA_WIDTH: registered FIFO write data.
REQ-012 fifoRdEnIn  in  1: FIFO read enable, observed for credit return.
REQ-013 fifoEmptyIn  in  1: FIFO empty flag.
REQ-014 creditOut  out  clog2(FIFO_DEPTH+1): registered count of free FIFO slots.
REQ-015 grantIdxOut  out  max(1,clog2(NUM_REQ)): registered index of the current or last owner.

Function
REQ-016 At most one ackOut bit SHALL be high per cycle, and only when creditOut>0.
REQ-017 Accept at cycle t SHALL produce wrEnOut=1, wrDataOut=winner data at t+1 (latency 1); otherwise wrEnOut=0 and wrDataOut holds.
REQ-018 Credit update SHALL be credit - accept + pop, where pop = fifoRdEnIn & ~fifoEmptyIn; simultaneous accept and pop SHALL leave credit unchanged.
REQ-019 Accept eligibility SHALL use the registered credit value only (no same-cycle pop bypass).
REQ-020 A pop at credit==FIFO_DEPTH SHALL be ignored (saturate); a pop with fifoEmptyIn=1 SHALL be ignored.
REQ-021 FSM states: IDLE (no owner) and OWN (owner register valid, burst counter active).
REQ-022 IDLE: winner SHALL be the first requesting index at or after the RR pointer, wrapping NUM_REQ-1 to 0; an accept SHALL move to OWN with owner=winner and burstCnt=1.
REQ-023 OWN: while owner reqIn is high, credit>0 and burstCnt<MAX_BURST, the owner SHALL win and burstCnt SHALL increment.
REQ-024 OWN release: owner reqIn low, or burstCnt==MAX_BURST, SHALL set RR pointer=owner+1 (wrapped) and re-arbitrate in the same cycle as in IDLE; if no accept results, the FSM SHALL go to IDLE.
REQ-025 Credit==0 in OWN SHALL stall without releasing the grant; burstCnt holds.
REQ-026 grantIdxOut SHALL update to the winner index on every accept.

Reset
REQ-027 While rstNIn=0 at a clock edge: wrEnOut=0, wrDataOut=0, creditOut=FIFO_DEPTH, grantIdxOut=0, FSM=IDLE, RR pointer=0, burstCnt=0.
REQ-028 ackOut SHALL be 0 in any cycle where rstNIn=0.
REQ-029 Reset mid-burst SHALL discard the ownership; an accept in the reset cycle SHALL NOT be issued.

Configuration
REQ-030 Macro FIFO_WR_ARB_BURST_EN defined: burst hold per REQ-023/024 with MAX_BURST.
REQ-031 Macro undefined: burst counter and OWN hold are removed; grant rotates after every accept (effective MAX_BURST=1); MAX_BURST is ignored.

Structure
REQ-032 Shared package/include fifo_arb_pkg SHALL hold the FSM state encodings (ST_IDLE, ST_OWN) and a clog2 function.
REQ-033 The round-robin pick SHALL be a combinational sub-module rr_pick(NUM_REQ): inputs reqIn and pointer; outputs one-hot and index.

Verification (NUM_REQ=4, FIFO_DEPTH=8, MAX_BURST=4, DATA_WIDTH=8)
REQ-034 reqIn=4'b1111 held through reset -> ackOut=0 and creditOut=8 during reset; first cycle after release ackOut=4'b0001.
REQ-035 reqIn=4'b0011 continuous, fifoRdEnIn=1, fifoEmptyIn=0 -> with BURST_EN the accepts are 0,0,0,0,1,1,1,1,...; without BURST_EN they are 0,1,0,1,...
REQ-036 Only req2 requests, data 0xA0.., no pops -> exactly 8 accepts, creditOut=0, ackOut=0 after that; one pop at t -> creditOut=1 at t+1 and one accept at t+1.
REQ-037 creditOut=3 with accept and pop in the same cycle -> creditOut=3; pop with fifoEmptyIn=1 -> no change.
REQ-038 Owner 1 at burstCnt=2, rstNIn=0 for 1 cycle -> next cycle wrEnOut=0, creditOut=8; after release req1|req3 -> req1 wins (pointer=0).
REQ-039 Every cycle: wrDataOut at t+1 equals the acked requester's reqDataIn at t, and ackOut is never multi-hot.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared FSM encodings and width helpers for the FIFO write arbiter
package fifo_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // Bits needed to hold values 0..value-1 (0 for value<=1)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO bundle between the arbiter and its environment
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8
) ();

  localparam int CW = clog2(FIFO_DEPTH + 1);
  localparam int IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]            reqIn;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn;
  logic [NUM_REQ-1:0]            ackOut;
  logic                          wrEnOut;
  logic [DATA_WIDTH-1:0]         wrDataOut;
  logic                          fifoRdEnIn;
  logic                          fifoEmptyIn;
  logic [CW-1:0]                 creditOut;
  logic [IW-1:0]                 grantIdxOut;

  // Arbiter side
  modport master (
    input  reqIn, reqDataIn, fifoRdEnIn, fifoEmptyIn,
    output ackOut, wrEnOut, wrDataOut, creditOut, grantIdxOut
  );

  // Requesters / FIFO side
  modport slave (
    output reqIn, reqDataIn, fifoRdEnIn, fifoEmptyIn,
    input  ackOut, wrEnOut, wrDataOut, creditOut, grantIdxOut
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin pick starting at a pointer
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqIn,
  input  logic [IW-1:0]      ptrIn,
  output logic [NUM_REQ-1:0] oneHotOut,
  output logic [IW-1:0]      idxOut,
  output logic               validOut
);

  // First requester at or after ptrIn, wrapping past NUM_REQ-1 to 0
  always_comb begin
    logic [IW:0] j;
    oneHotOut = '0;
    idxOut    = '0;
    validOut  = 1'b0;
    j         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, ptrIn} + (IW+1)'(k);
      if (j >= (IW+1)'(NUM_REQ)) j = j - (IW+1)'(NUM_REQ);
      if (!validOut && reqIn[j[IW-1:0]]) begin
        validOut             = 1'b1;
        idxOut               = j[IW-1:0];
        oneHotOut[j[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - credit-gated round-robin write arbiter; FIFO_WR_ARB_BURST_EN enables burst ownership
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic                clkIn,
  input logic                rstNIn,
  fifo_wr_arbiter_if.master  bus
);

  localparam int CW = clog2(FIFO_DEPTH + 1);
  localparam int IW = idx_width(NUM_REQ);

  // Reject configurations the arbiter is not built for
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_num_req_chk
    $error("NUM_REQ must be in 2..16");
  end
  if (MAX_BURST < 1) begin : g_max_burst_chk
    $error("MAX_BURST must be at least 1");
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(NUM_REQ - 1)) return '0;
    return v + IW'(1);
  endfunction

  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [IW-1:0]         grant_q, grant_d;

  logic [IW-1:0]         pick_ptr;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IW-1:0]         pick_idx;
  logic                  pick_valid;

  logic                  accept;
  logic [IW-1:0]         win_idx;
  logic [NUM_REQ-1:0]    ack;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  pop;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int BW = clog2(MAX_BURST + 1);

  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          owner_keeps;

  assign owner_keeps = bus.reqIn[owner_q] && (burst_q < BW'(MAX_BURST));

  // A releasing owner hands the search start to the requester after it
  always_comb begin
    pick_ptr = ptr_q;
    if (state_q == ST_OWN && !owner_keeps) pick_ptr = wrap_inc(owner_q);
  end
`else
  assign pick_ptr = ptr_q;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .reqIn     (bus.reqIn),
    .ptrIn     (pick_ptr),
    .oneHotOut (pick_onehot),
    .idxOut    (pick_idx),
    .validOut  (pick_valid)
  );

  // Grant decision, next ownership, credit and write-port next state
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    accept    = 1'b0;
    win_idx   = pick_idx;
    ack       = '0;
`ifdef FIFO_WR_ARB_BURST_EN
    owner_d   = owner_q;
    burst_d   = burst_q;
    if (rstNIn) begin
      if (state_q == ST_OWN) begin
        // No credit: the owner keeps the grant and its burst count
        if (credit_q != '0) begin
          if (owner_keeps) begin
            accept       = 1'b1;
            win_idx      = owner_q;
            ack[owner_q] = 1'b1;
            burst_d      = burst_q + BW'(1);
          end else begin
            ptr_d = pick_ptr;
            if (pick_valid) begin
              accept  = 1'b1;
              ack     = pick_onehot;
              owner_d = pick_idx;
              burst_d = BW'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end else if (credit_q != '0 && pick_valid) begin
        accept  = 1'b1;
        ack     = pick_onehot;
        state_d = ST_OWN;
        owner_d = pick_idx;
        burst_d = BW'(1);
      end
    end
`else
    // Without bursts the pointer moves past every winner immediately
    state_d = ST_IDLE;
    if (rstNIn && credit_q != '0 && pick_valid) begin
      accept = 1'b1;
      ack    = pick_onehot;
      ptr_d  = wrap_inc(pick_idx);
    end
`endif

    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) win_data = bus.reqDataIn[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pops are only believed when the FIFO is non-empty and not already fully credited
    pop = bus.fifoRdEnIn && !bus.fifoEmptyIn && (credit_q != CW'(FIFO_DEPTH));

    credit_d = credit_q;
    if (accept && !pop)      credit_d = credit_q - CW'(1);
    else if (!accept && pop) credit_d = credit_q + CW'(1);

    wr_en_d   = accept;
    wr_data_d = accept ? win_data : wr_data_q;
    grant_d   = accept ? win_idx : grant_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      credit_q  <= CW'(FIFO_DEPTH);
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      grant_q   <= '0;
`ifdef FIFO_WR_ARB_BURST_EN
      owner_q   <= '0;
      burst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      credit_q  <= credit_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      grant_q   <= grant_d;
`ifdef FIFO_WR_ARB_BURST_EN
      owner_q   <= owner_d;
      burst_q   <= burst_d;
`endif
    end
  end

  assign bus.ackOut      = ack;
  assign bus.wrEnOut     = wr_en_q;
  assign bus.wrDataOut   = wr_data_q;
  assign bus.creditOut   = credit_q;
  assign bus.grantIdxOut = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed checks of fifo_wr_arbiter against a behavioural model
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int MB    = 4;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam int LIMIT = MB;
`else
  localparam int LIMIT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N), .FIFO_DEPTH(DEPTH)) bus ();

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .FIFO_DEPTH (DEPTH),
    .MAX_BURST  (MB)
  ) dut (
    .clkIn  (clk),
    .rstNIn (rst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: owner -1 means nobody holds the grant
  int m_credit, m_ptr, m_owner, m_burst, m_wren, m_wrdata, m_grant;

  logic [N-1:0]    cur_req;
  logic [N*DW-1:0] cur_data;
  logic            cur_rden, cur_empty;

  logic [N-1:0] obs_ack;
  int           obs_credit, obs_wren;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) begin
      if (req[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a == (N'(1) << i)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_credit = DEPTH; m_ptr = 0; m_owner = -1; m_burst = 0;
    m_wren = 0; m_wrdata = 0; m_grant = 0;
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] req, input logic [N*DW-1:0] data,
                       input logic rden, input logic empty);
    rst_n = rst;
    cur_req = req; cur_data = data; cur_rden = rden; cur_empty = empty;
    bus.reqIn = req; bus.reqDataIn = data; bus.fifoRdEnIn = rden; bus.fifoEmptyIn = empty;
  endtask

  // Called just after a falling edge with inputs applied; returns on the next falling edge
  task automatic step();
    int win;
    logic [N-1:0] exp_ack;
    logic pop;
    #1;
    win = -1;
    if (rst_n) begin
      if (m_owner >= 0) begin
        if (m_credit == 0) win = -1;
        else if (cur_req[m_owner] && m_burst < LIMIT) win = m_owner;
        else begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          win = rr_first(cur_req, m_ptr);
        end
      end else if (m_credit > 0) begin
        win = rr_first(cur_req, m_ptr);
      end
    end
    exp_ack = (win >= 0) ? (N'(1) << win) : '0;
    obs_ack = bus.ackOut;
    obs_credit = int'(bus.creditOut);
    obs_wren = int'(bus.wrEnOut);
    check_val("ack", obs_ack, exp_ack);
    check_val("ack_onehot", ($countones(obs_ack) <= 1) ? 1 : 0, 1);
    check_val("wr_en", obs_wren, m_wren);
    check_val("wr_data", bus.wrDataOut, m_wrdata);
    check_val("credit", obs_credit, m_credit);
    check_val("grant_idx", bus.grantIdxOut, m_grant);
    if (!rst_n) begin
      model_reset();
    end else begin
      pop = cur_rden && !cur_empty && (m_credit < DEPTH);
      if (win >= 0) begin
        if (win == m_owner) m_burst++;
        else begin m_owner = win; m_burst = 1; end
        m_wren = 1;
        m_wrdata = int'((cur_data >> (win * DW)) & 32'hFF);
        m_grant = win;
        m_credit--;
      end else begin
        m_wren = 0;
      end
      if (pop) m_credit++;
    end
    @(negedge clk);
  endtask

  initial begin
    int win_log[12];
    int acc_cnt;
    logic [N*DW-1:0] d;

    model_reset();
    drive(1'b0, 4'b1111, 32'h44332211, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // Requests held through reset, then the first grant goes to requester 0
    for (int i = 0; i < 3; i++) step();
    check_val("rst_ack_zero", obs_ack, 4'b0000);
    check_val("rst_credit", obs_credit, DEPTH);
    drive(1'b1, 4'b1111, 32'h44332211, 1'b0, 1'b0);
    step();
    check_val("first_ack", obs_ack, 4'b0001);

    // Two requesters with continuous pops: burst-length alternation
    drive(1'b0, 4'b0011, 32'h0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 4'b0011, {8'h04, 8'h03, 8'h10 + 8'(i), 8'h20 + 8'(i)}, 1'b1, 1'b0);
      step();
      win_log[i] = onehot_idx(obs_ack);
    end
    for (int i = 0; i < 8; i++) check_val("rr_pattern", win_log[i], (i / LIMIT) % 2);

    // Lone requester drains all credit, then one pop frees one slot
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      d = {8'h33, 8'hA0 + 8'(i), 8'h11, 8'h00};
      drive(1'b1, 4'b0100, d, 1'b0, 1'b0);
      step();
      if (obs_ack != 0) acc_cnt++;
    end
    check_val("drain_accepts", acc_cnt, 8);
    check_val("drain_credit", bus.creditOut, 0);
    drive(1'b1, 4'b0100, {8'h33, 8'hAA, 8'h11, 8'h00}, 1'b1, 1'b0);
    step();
    check_val("no_bypass_ack", obs_ack, 4'b0000);
    drive(1'b1, 4'b0100, {8'h33, 8'hAB, 8'h11, 8'h00}, 1'b0, 1'b0);
    step();
    check_val("pop_credit", obs_credit, 1);
    check_val("pop_ack", obs_ack, 4'b0100);

    // Credit 3 with simultaneous accept and pop, then a pop against an empty FIFO
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0001, {24'h0, 8'h50 + 8'(i)}, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 4'b0001, 32'h0000005F, 1'b1, 1'b0);
    step();
    check_val("credit3_pre", obs_credit, 3);
    drive(1'b1, 4'b0000, 32'h0, 1'b1, 1'b1);
    step();
    check_val("acc_pop_credit", obs_credit, 3);
    drive(1'b1, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();
    check_val("empty_pop_credit", obs_credit, 3);

    // Reset in the middle of requester 1's burst
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b0010, {16'h0, 8'h70 + 8'(i), 8'h0}, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 4'b0010, 32'h00007700, 1'b0, 1'b0);
    step();
    check_val("midrst_ack", obs_ack, 4'b0000);
    drive(1'b1, 4'b1010, 32'h99008800, 1'b0, 1'b0);
    step();
    check_val("midrst_wren", obs_wren, 0);
    check_val("midrst_credit", obs_credit, DEPTH);
    check_val("midrst_winner", obs_ack, 4'b0010);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 39) != 0), N'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
